// File: rtl/aes_inv_cipher_iter_if.sv
// rtl/aes_inv_cipher_iter_if.sv - ciphertext/plaintext handshake and key-schedule bundle for the iterative AES-128 decryptor
interface aes_inv_cipher_iter_if #(
    parameter int NUM_ROUNDS = 10,
    parameter int BLOCK_W    = 128
);
    logic                                in_valid;
    logic                                in_ready;
    logic [BLOCK_W-1:0]                  ciphertext;
    logic [(NUM_ROUNDS+1)*BLOCK_W-1:0]   round_keys;
    logic                                out_valid;
    logic                                out_ready;
    logic [BLOCK_W-1:0]                  plaintext;
    logic                                busy;

    modport master (
        output in_valid, ciphertext, round_keys, out_ready,
        input  in_ready, out_valid, plaintext, busy
    );

    modport slave (
        input  in_valid, ciphertext, round_keys, out_ready,
        output in_ready, out_valid, plaintext, busy
    );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES-128 decryption sequencer and the inverse round it drives
module aes_inv_round (
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic [127:0] state_out
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps zero to zero as the S-box needs
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
        return gf_mul(r, r);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    logic [127:0] ark;
    logic [127:0] mixed;
    logic [127:0] shifted;

    // Byte 0 sits in the MSBs; columns are four consecutive bytes, row r is rotated right by r
    always_comb begin
        ark       = state_in ^ round_key;
        mixed     = ark;
        shifted   = '0;
        state_out = '0;
        if (!last_round) begin
            for (int c = 0; c < 4; c++)
                mixed[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                shifted[127-8*(4*c+r) -: 8] = mixed[127-8*(4*((c+4-r)%4)+r) -: 8];
        for (int i = 0; i < 16; i++)
            state_out[127-8*i -: 8] = inv_sbox(shifted[127-8*i -: 8]);
    end
endmodule

module aes_inv_cipher_iter #(
    parameter int NUM_ROUNDS = 10,
    parameter int BLOCK_W    = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    aes_inv_cipher_iter_if.slave   bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [3:0] LAST_CNT = 4'(NUM_ROUNDS - 1);

    logic [1:0]         state;
    logic [3:0]         cnt;
    logic [BLOCK_W-1:0] st;
    logic [BLOCK_W-1:0] plaintext_q;
    logic               out_valid_q;
    logic [3:0]         key_idx;
    logic [BLOCK_W-1:0] round_key;
    logic [BLOCK_W-1:0] round_out;

    // Clamp keeps the key mux in range if the counter is ever corrupted
    assign key_idx   = (cnt > LAST_CNT) ? 4'(NUM_ROUNDS) : 4'(NUM_ROUNDS) - cnt;
    assign round_key = bus.round_keys[int'(key_idx) * BLOCK_W +: BLOCK_W];

    aes_inv_round u_round (
        .state_in   (st),
        .round_key  (round_key),
        .last_round (cnt == 4'd0),
        .state_out  (round_out)
    );

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.busy      = (state == S_ROUND) || (state == S_DONE);
    assign bus.out_valid = out_valid_q;
    assign bus.plaintext = plaintext_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            st          <= '0;
            plaintext_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        st    <= bus.ciphertext;
                        cnt   <= 4'd0;
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (cnt > LAST_CNT) begin
                        cnt   <= 4'd0;
                        state <= S_IDLE;
                    end else if (cnt == LAST_CNT) begin
                        plaintext_q <= round_out ^ bus.round_keys[BLOCK_W-1:0];
                        out_valid_q <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        st  <= round_out;
                        cnt <= cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    cnt         <= 4'd0;
                    out_valid_q <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 decryption sequencer; sits directly upstream of aes_inv_round and drives it.
- Instantiates one aes_inv_round and loops a 128-bit state register through it once per clock, selecting the round key and the last_round (skip-InvMixColumns) flag each pass.
- Applies the final AddRoundKey with k0 itself and presents the plaintext on a valid/ready output handshake.
- Ciphertext enters on a valid/ready input handshake; the expanded key schedule comes from the key-expansion block.

Parameters:
- NUM_ROUNDS, 10, number of aes_inv_round passes; only 10 (AES-128) is supported.
- BLOCK_W, 128, state and round-key width in bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  block can accept a ciphertext; high only in IDLE.
- ciphertext  in  128  input block, captured on accept.
- round_keys  in  1408  expanded schedule; key k_r is bits [r*128 +: 128], r = 0..10. Must be held stable from accept until the output handshake completes; it is not latched.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  downstream accepts the plaintext.
- plaintext  out  128  decrypted block, registered.
- busy  out  1  high in ROUND or DONE.

Behaviour:
- States: IDLE, ROUND, DONE; 4-bit round counter cnt; 128-bit register st.
- Reset (asynchronous, any state): state = IDLE, cnt = 0, st = 0, plaintext = 0, out_valid = 0, busy = 0. in_ready is 1 once reset deasserts. An in-flight block is discarded; no partial output ever appears.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: st <= ciphertext, cnt <= 0, go to ROUND.
- ROUND:
  - The round instance sees state_in = st, round_key = k_(10-cnt), last_round = (cnt == 0).
  - Pass 0 does AddRoundKey(k10), InvShiftRows, InvSubBytes (no InvMixColumns).
  - Passes 1..9 do AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes.
  - For cnt < 9: st <= state_out, cnt <= cnt + 1.
  - For cnt == 9: plaintext <= state_out ^ k0, out_valid <= 1, go to DONE.
- Latency: accept at edge E; out_valid is high after edge E+10 (10 ROUND cycles). Throughput is one block per 11 cycles plus the output handshake.
- DONE:
  - plaintext and out_valid are held stable while out_ready = 0 (no drops, no changes).
  - On out_valid && out_ready: out_valid <= 0, go to IDLE. in_ready rises the following cycle; there is no same-cycle accept of a new block.
- While busy: in_ready = 0, and in_valid and ciphertext are ignored.
- The counter never exceeds 9; any illegal state or counter value returns to IDLE on the next edge.
- Arithmetic: XOR only. Key index 10-cnt is computed over 4 bits with range 1..10 in ROUND; k0 is used only in the final XOR.

Test Plan:
- FIPS-197 C.1: schedule from key 000102030405060708090a0b0c0d0e0f (k10 = 13111d7fe3944a17f307a78b4d2b30c5), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff with out_valid high exactly 10 cycles after the accept edge.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ciphertext 3925841d02dc09fbdc118597196a0b32 -> plaintext 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid -> plaintext/out_valid stable, in_ready = 0, a new in_valid is ignored; out_ready = 1 -> out_valid drops next edge, in_ready = 1 the cycle after.
- Back-to-back: two C.1 blocks with in_valid held high and out_ready = 1 -> both outputs correct, second accept occurs one cycle after the first output handshake.
- Reset at cnt = 5 -> out_valid = 0, plaintext = 0, in_ready = 1; a fresh C.1 block then decrypts correctly.
- in_valid pulsed while busy with ciphertext 00..00 -> ignored; the original block's plaintext is unchanged.
